line_fill_buffer: RTL and testbench
===================================

# line_fill_buffer

Assembles one cache line from a narrow physical-memory read port and hands the completed line to the cache data array and word selector. It sits between physical memory and the cache datapath. A fill request is turned into a sequence of beat reads at ascending addresses. Each returned beat is packed into a line register, and a one-cycle `line_valid` is pulsed when the line is complete.

## Interface
- `LINE_WIDTH`, default 128: line size in bits. Must be an integer multiple of `BEAT_WIDTH`.
- `BEAT_WIDTH`, default 32: memory beat size in bits. Must be a multiple of 8.
- Derived values: `BEATS = LINE_WIDTH/BEAT_WIDTH` (4 at defaults); `BEAT_BYTES = BEAT_WIDTH/8`; `LINE_BYTES = LINE_WIDTH/8`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: the single clock. All state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `fill_req` in 1: start-fill request from the cache controller. Sampled only in IDLE.
- `fill_addr` in 16: LC-3b byte address anywhere inside the target line.
- `busy` out 1: high in FILL and DONE.
- `mem_read` out 1: beat read strobe to physical memory.
- `mem_address` out 16: byte address of the current beat.
- `mem_rdata` in `BEAT_WIDTH`: returned beat data.
- `mem_resp` in 1: beat data valid this cycle. One beat per cycle.
- `line_out` out `LINE_WIDTH`: last completed line. Held until the next completion.
- `line_valid` out 1: one-cycle pulse when `line_out` has just been updated.

## Operation
- States: IDLE, FILL, DONE.
- IDLE:
  - Outputs: `mem_read=0`, `busy=0`.
  - On `fill_req=1`: latch `base = fill_addr` with the low log2(`LINE_BYTES`) bits cleared, set beat index `idx=0`, go to FILL.
  - `mem_resp` is ignored.
- FILL:
  - Outputs: `mem_read=1`, `mem_address = base + idx*BEAT_BYTES`.
  - On `mem_resp=1`: write `mem_rdata` into shadow bits `[idx*BEAT_WIDTH +: BEAT_WIDTH]`.
  - If `idx == BEATS-1`, go to DONE; otherwise `idx` increments.
  - `mem_resp=0` stalls indefinitely with the address held stable.
- DONE:
  - Outputs: `line_out <= shadow`, `line_valid=1` for exactly this cycle, `mem_read=0`.
  - Return to IDLE unconditionally.
- `fill_req` outside IDLE is ignored. It is not queued, so the controller holds or reissues it.
- `mem_resp` in IDLE or DONE is ignored. Shadow and `line_out` are unchanged.
- Address arithmetic is 16-bit. Because `base` is line-aligned, beat offsets never carry out of the line. A line at 0xFFF0 reads 0xFFF0, 0xFFF4, 0xFFF8, 0xFFFC with no wrap.
- `line_out` changes only in DONE. A partially filled shadow is never visible.

## Timing
- Reset values: state IDLE, `idx=0`, `busy=0`, `mem_read=0`, `mem_address=0`, `line_out=0`, `line_valid=0`, shadow `0`.
- Reset asserted mid-fill aborts immediately. Partial beats are discarded, `line_out` returns to 0, and `mem_read` drops asynchronously.
- `mem_read` and `mem_address` are registered outputs, or are decoded only from registered state. They have no combinational path from `fill_req` or `mem_resp`.
- Latency with `fill_req` sampled at edge 0 and `mem_resp` high every FILL cycle:
  - FILL occupies cycles 1..`BEATS`.
  - `line_valid` is high in cycle `BEATS+1` (cycle 5 at defaults).
  - IDLE resumes in cycle `BEATS+2`.
- Each stall cycle (`mem_resp=0` in FILL) adds exactly one cycle.
- Earliest next fill: a `fill_req` sampled in the first IDLE cycle after DONE. Back-to-back fills therefore cost `BEATS+2` cycles each.
- `line_valid` and `line_out` update on the same edge, so the consumer samples both together.

## Test plan
- Reset, then `fill_req` with `fill_addr=0x1236`, `mem_resp` tied high, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444. Required:
  - `mem_address` reads 0x1230, 0x1234, 0x1238, 0x123C.
  - `line_valid` pulses in cycle 5 with `line_out=0x44444444_33333333_22222222_11111111`.
- Same fill with `mem_resp` low for 2 cycles before beat 2. Required: `mem_address` holds 0x1238 during the stall, and `line_valid` arrives in cycle 7.
- `fill_addr=0xFFFE`. Required: addresses 0xFFF0, 0xFFF4, 0xFFF8, 0xFFFC, with no wrap to 0x0000.
- `fill_req` pulsed during FILL and during DONE, plus `mem_resp` pulsed in IDLE. Required: no second fill starts, and `line_out` is unchanged until the next genuine IDLE request.
- Complete a fill of 0xAAAA… pattern, start a second fill, then assert `reset_n=0` after 2 beats. Required: immediately `mem_read=0`, `line_out=0`, `busy=0`, with no `line_valid`. A new fill after release completes normally.
- Parameter sweep with `BEAT_WIDTH=64` and `BEAT_WIDTH=16`. Required: 2 and 8 beats respectively, address stride 8 and 2, `line_valid` in cycle `BEATS+1`, correct packing.

Source files
------------

// File: rtl/line_fill_buffer.sv
// Line fill buffer: issues ascending beat reads for one cache line,
// packs the returned beats and publishes the whole line with a 1-cycle pulse.
module line_fill_buffer #(
   parameter int LINE_WIDTH = 128,
   parameter int BEAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  fill_req,
   input  logic [15:0]           fill_addr,
   output logic                  busy,
   output logic                  mem_read,
   output logic [15:0]           mem_address,
   input  logic [BEAT_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp,
   output logic [LINE_WIDTH-1:0] line_out,
   output logic                  line_valid
);

   localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
   localparam int BEAT_BYTES = BEAT_WIDTH / 8;
   localparam int LINE_BYTES = LINE_WIDTH / 8;
   localparam int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } state_t;

   state_t                state_q;
   logic [IDX_W-1:0]      idx_q;
   logic [15:0]           addr_q;
   logic                  rd_q;
   logic                  busy_q;
   logic                  lv_q;
   logic [LINE_WIDTH-1:0] shadow_q;
   logic [LINE_WIDTH-1:0] shadow_d;
   logic [LINE_WIDTH-1:0] line_q;
   logic [15:0]           base;
   logic                  last;

   assign base = fill_addr & ~16'(LINE_BYTES - 1);
   assign last = (idx_q == IDX_W'(BEATS - 1));

   // Shadow with the current beat merged, so the final beat can go
   // straight into line_out on the same edge that enters DONE.
   always_comb begin
      shadow_d = shadow_q;
      shadow_d[int'(idx_q)*BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         busy_q   <= 1'b0;
         lv_q     <= 1'b0;
         shadow_q <= '0;
         line_q   <= '0;
      end else begin
         lv_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (fill_req) begin
                  addr_q  <= base;
                  idx_q   <= '0;
                  rd_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= FILL;
               end
            end
            FILL: begin
               if (mem_resp) begin
                  shadow_q <= shadow_d;
                  if (last) begin
                     rd_q    <= 1'b0;
                     line_q  <= shadow_d;
                     lv_q    <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     idx_q  <= idx_q + 1'b1;
                     addr_q <= addr_q + 16'(BEAT_BYTES);
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               idx_q   <= '0;
               state_q <= IDLE;
            end
            default: begin
               rd_q    <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign mem_read    = rd_q;
   assign mem_address = addr_q;
   assign line_out    = line_q;
   assign line_valid  = lv_q;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Scoreboard bench for line_fill_buffer at beat widths 32, 64 and 16
// sharing one clock and reset.
module tb_line_fill_buffer;

   logic              clk;
   logic              rst_n;
   logic [15:0]       fill_addr;
   logic [63:0]       rdata;
   logic [2:0]        freq;
   logic [2:0]        resp;
   logic [2:0]        rd;
   logic [2:0]        bsy;
   logic [2:0]        lv;
   logic [2:0][15:0]  ad;
   logic [2:0][127:0] lo;

   int n_chk;
   int n_fail;

   logic [15:0]  exp_addr[$];
   logic [127:0] exp_line[$];

   line_fill_buffer #(.LINE_WIDTH(128), .BEAT_WIDTH(32)) u_dut (
      .clk(clk), .reset_n(rst_n), .fill_req(freq[0]),
      .fill_addr(fill_addr), .busy(bsy[0]), .mem_read(rd[0]),
      .mem_address(ad[0]), .mem_rdata(rdata[31:0]),
      .mem_resp(resp[0]), .line_out(lo[0]), .line_valid(lv[0])
   );

   line_fill_buffer #(.LINE_WIDTH(128), .BEAT_WIDTH(64)) u_dut64 (
      .clk(clk), .reset_n(rst_n), .fill_req(freq[1]),
      .fill_addr(fill_addr), .busy(bsy[1]), .mem_read(rd[1]),
      .mem_address(ad[1]), .mem_rdata(rdata),
      .mem_resp(resp[1]), .line_out(lo[1]), .line_valid(lv[1])
   );

   line_fill_buffer #(.LINE_WIDTH(128), .BEAT_WIDTH(16)) u_dut16 (
      .clk(clk), .reset_n(rst_n), .fill_req(freq[2]),
      .fill_addr(fill_addr), .busy(bsy[2]), .mem_read(rd[2]),
      .mem_address(ad[2]), .mem_rdata(rdata[15:0]),
      .mem_resp(resp[2]), .line_out(lo[2]), .line_valid(lv[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // pat: 0 random, 1 all 0xAA, 2 beat b = 0x11..11*(b+1)
   task automatic do_fill(input int s, input logic [15:0] a,
                          input int stall_beat, input int nstall,
                          input bit glitch, input int abort_at,
                          input int pat);
      int bw, nb, beat, stalled;
      bit done;
      logic [63:0] d[$];
      logic [63:0] m, v;
      logic [127:0] le, held;
      logic [15:0] base;
      bw = (s == 0) ? 32 : (s == 1) ? 64 : 16;
      nb = 128 / bw;
      m = (bw == 64) ? '1 : ((64'd1 << bw) - 64'd1);
      base = a & 16'hFFF0;
      le = '0;
      for (int b = 0; b < nb; b++) begin
         if (pat == 1) v = 64'hAAAA_AAAA_AAAA_AAAA;
         else if (pat == 2) v = 64'h1111_1111_1111_1111 * 64'(b + 1);
         else v = {$urandom, $urandom};
         v = v & m;
         d.push_back(v);
         le = le | (128'(v) << (b * bw));
         exp_addr.push_back(base + 16'(b * bw / 8));
      end
      if (abort_at < 0) exp_line.push_back(le);
      @(negedge clk);
      fill_addr = a;
      freq[s] = 1'b1;
      @(posedge clk);
      #1 freq[s] = 1'b0;
      beat = 0;
      stalled = 0;
      done = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         resp[s] = 1'b0;
         freq[s] = 1'b0;
         if (abort_at >= 0 && beat == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_read", 128'(rd[s]), 128'd0);
            chk("rst_busy", 128'(bsy[s]), 128'd0);
            chk("rst_line", lo[s], 128'd0);
            chk("rst_valid", 128'(lv[s]), 128'd0);
            @(posedge clk);
            #1 chk("rst_hold", 128'({rd[s], bsy[s], lv[s]}), 128'd0);
            @(negedge clk);
            rst_n = 1'b1;
            exp_addr.delete();
            return;
         end
         if (lv[s]) begin
            if (exp_line.size() > 0)
               chk("line", lo[s], exp_line.pop_front());
            else
               chk("line_extra", 128'd1, 128'd0);
            chk("valid_cycle", 128'(c), 128'(nb + 1 + nstall));
            chk("done_read", 128'(rd[s]), 128'd0);
            if (glitch) begin
               freq[s] = 1'b1;
               resp[s] = 1'b1;
               rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            done = 1'b1;
            break;
         end
         if (rd[s]) begin
            if (beat == stall_beat && stalled < nstall) begin
               stalled++;
               chk("stall_addr", 128'(ad[s]), 128'(exp_addr[0]));
            end else begin
               chk("addr", 128'(ad[s]), 128'(exp_addr.pop_front()));
               rdata = d[beat];
               resp[s] = 1'b1;
               beat++;
               if (glitch && beat == 2) freq[s] = 1'b1;
            end
         end
      end
      if (!done) chk("valid_timeout", 128'd0, 128'd1);
      held = lo[s];
      @(negedge clk);
      chk("pulse_end", 128'(lv[s]), 128'd0);
      chk("idle_busy", 128'(bsy[s]), 128'd0);
      freq[s] = 1'b0;
      resp[s] = glitch;
      rdata = 64'h0BAD_0BAD_0BAD_0BAD;
      if (glitch) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ign_busy", 128'(bsy[s]), 128'd0);
            chk("ign_line", lo[s], held);
         end
      end
      resp[s] = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      freq = '0;
      resp = '0;
      rdata = '0;
      fill_addr = '0;
      @(negedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         chk("reset_read", 128'(rd[s]), 128'd0);
         chk("reset_busy", 128'(bsy[s]), 128'd0);
         chk("reset_addr", 128'(ad[s]), 128'd0);
         chk("reset_line", lo[s], 128'd0);
         chk("reset_valid", 128'(lv[s]), 128'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      do_fill(0, 16'h1236, -1, 0, 1'b0, -1, 2);
      chk("known_line", lo[0],
          128'h44444444_33333333_22222222_11111111);
      do_fill(0, 16'h1236, 2, 2, 1'b0, -1, 2);
      do_fill(0, 16'hFFFE, -1, 0, 1'b0, -1, 0);
      do_fill(0, 16'h0400, -1, 0, 1'b1, -1, 0);
      do_fill(0, 16'h2000, -1, 0, 1'b0, -1, 1);
      chk("aa_line", lo[0], {4{32'hAAAA_AAAA}});
      do_fill(0, 16'h3004, -1, 0, 1'b0, 2, 0);
      do_fill(0, 16'h3008, -1, 0, 1'b0, -1, 0);
      do_fill(1, 16'h5555, -1, 0, 1'b0, -1, 0);
      do_fill(1, 16'hFFF7, 1, 1, 1'b0, -1, 0);
      do_fill(2, 16'hABCD, -1, 0, 1'b0, -1, 0);
      do_fill(2, 16'h7FF1, 5, 3, 1'b0, -1, 0);

      chk("addr_q_empty", 128'(exp_addr.size()), 128'd0);
      chk("line_q_empty", 128'(exp_line.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
